// File: rtl/cop0_regfile.sv
// Coprocessor-0 register file.
//
// Receives the committed COP0 write at writeback (MTC0 data, a Status value
// already modified by ERET/EI/DI, or an LL address). It also records exception
// state in EPC, Cause and BadVAddr, runs the Count/Compare timer, and samples
// the hardware interrupt lines.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   we/waddr/wsel/wdata committed COP0 write
//   raddr/rsel/rdata    combinational read port (no write bypass)
//   exc_*               exception commit: code, PC, delay-slot flag, BadVAddr
//   ll_set, eret        LL link-bit set / clear
//   hw_int              level-sensitive external interrupt lines
//   status_out, cause_out, epc_out, errorepc_out   live register values
//   llbit, int_pending  link bit, interrupt request
module cop0_regfile #(
  parameter logic [31:0] PRID      = 32'h0001_8000,
  parameter logic [31:0] CONFIG    = 32'h8000_0000,
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [2:0]  wsel,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  input  logic [2:0]  rsel,
  output logic [31:0] rdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_badvaddr_we,
  input  logic [31:0] exc_badvaddr,
  input  logic        ll_set,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] status_out,
  output logic [31:0] cause_out,
  output logic [31:0] epc_out,
  output logic [31:0] errorepc_out,
  output logic        llbit,
  output logic        int_pending
);

  localparam int unsigned DivW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;
  localparam logic [4:0] RegPrid     = 5'd15;
  localparam logic [4:0] RegConfig   = 5'd16;
  localparam logic [4:0] RegLlAddr   = 5'd17;
  localparam logic [4:0] RegErrorEpc = 5'd30;

  localparam logic [31:0] StatusMask  = 32'h0040_FF07;
  localparam logic [31:0] StatusReset = 32'h0040_0004;

  logic [31:0]     status_q, epc_q, errorepc_q, badvaddr_q, count_q, compare_q;
  logic [27:0]     lladdr_q;
  logic            bd_q, ti_q, llbit_q;
  logic [4:0]      exccode_q;
  logic [1:0]      ip_sw_q;
  logic [5:0]      ip_hw_q;  // Cause.IP[7:2]
  logic [DivW-1:0] div_q;

  logic [31:0]     count_d;
  logic [DivW-1:0] div_d;
  logic            ti_d;
  logic            wr_en;
  logic            div_wrap;

  // An exception in the same cycle drops the committed write.
  assign wr_en    = we & ~exc_valid & (wsel == 3'd0);
  assign div_wrap = (div_q == DivW'(COUNT_DIV - 1));

  always_comb begin
    div_d   = div_wrap ? '0 : div_q + DivW'(1);
    count_d = div_wrap ? count_q + 32'd1 : count_q;
    if (wr_en && waddr == RegCount) begin
      div_d   = '0;
      count_d = wdata;
    end
  end

  // Compare match is taken from registered Count/Compare; a Compare write
  // clears TI even when a match is seen in the same cycle.
  always_comb begin
    ti_d = ti_q;
    if (count_q == compare_q) ti_d = 1'b1;
    if (wr_en && waddr == RegCompare) ti_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q   <= StatusReset;
      epc_q      <= '0;
      errorepc_q <= '0;
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= 32'hFFFF_FFFF;
      lladdr_q   <= '0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      llbit_q    <= 1'b0;
      exccode_q  <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      div_q      <= '0;
    end else begin
      div_q   <= div_d;
      count_q <= count_d;
      ti_q    <= ti_d;
      // IP7 carries the timer so TI and IP7 rise on the same edge.
      ip_hw_q <= {ti_d | hw_int[5], hw_int[4:0]};

      if (exc_valid) begin
        // Nested exceptions (EXL already set) keep the original EPC/BD.
        if (!status_q[1]) begin
          epc_q <= exc_pc;
          bd_q  <= exc_bd;
        end
        exccode_q   <= exc_code;
        status_q[1] <= 1'b1;
        if (exc_badvaddr_we) badvaddr_q <= exc_badvaddr;
      end else if (wr_en) begin
        case (waddr)
          RegBadVAddr: badvaddr_q <= wdata;
          RegCompare:  compare_q  <= wdata;
          RegStatus:   status_q   <= wdata & StatusMask;
          RegCause:    ip_sw_q    <= wdata[9:8];
          RegEpc:      epc_q      <= wdata;
          RegLlAddr:   lladdr_q   <= wdata[31:4];
          RegErrorEpc: errorepc_q <= wdata;
          default: ;
        endcase
      end

      if (eret) begin
        llbit_q <= 1'b0;
      end else if (ll_set) begin
        llbit_q <= 1'b1;
      end
    end
  end

  always_comb begin
    cause_out = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};
  end

  always_comb begin
    rdata = '0;
    if (rsel == 3'd0) begin
      case (raddr)
        RegBadVAddr: rdata = badvaddr_q;
        RegCount:    rdata = count_q;
        RegCompare:  rdata = compare_q;
        RegStatus:   rdata = status_q;
        RegCause:    rdata = cause_out;
        RegEpc:      rdata = epc_q;
        RegPrid:     rdata = PRID;
        RegConfig:   rdata = CONFIG;
        RegLlAddr:   rdata = {4'b0, lladdr_q};
        RegErrorEpc: rdata = errorepc_q;
        default:     rdata = '0;
      endcase
    end
  end

  assign status_out   = status_q;
  assign epc_out      = epc_q;
  assign errorepc_out = errorepc_q;
  assign llbit        = llbit_q;
  assign int_pending  = status_q[0] & ~status_q[1] & ~status_q[2] &
                        (|({ip_hw_q, ip_sw_q} & status_q[15:8]));

endmodule

// File: tb/tb_cop0_regfile.sv
// Bench for cop0_regfile: directed walk through the main behaviours followed by
// randomized traffic, all checked against a behavioural model of the register
// file kept here.
module tb_cop0_regfile;

  localparam logic [31:0] PRID      = 32'h0001_8000;
  localparam logic [31:0] CONFIG    = 32'h8000_0000;
  localparam int          COUNT_DIV = 2;

  logic        clk = 1'b0;
  logic        reset, we, exc_valid, exc_bd, exc_badvaddr_we, ll_set, eret;
  logic [4:0]  waddr, raddr, exc_code;
  logic [2:0]  wsel, rsel;
  logic [31:0] wdata, rdata, exc_pc, exc_badvaddr;
  logic [5:0]  hw_int;
  logic [31:0] status_out, cause_out, epc_out, errorepc_out;
  logic        llbit, int_pending;

  int n_cmp = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  cop0_regfile #(.PRID(PRID), .CONFIG(CONFIG), .COUNT_DIV(COUNT_DIV)) dut (
    .clk             (clk),
    .reset           (reset),
    .we              (we),
    .waddr           (waddr),
    .wsel            (wsel),
    .wdata           (wdata),
    .raddr           (raddr),
    .rsel            (rsel),
    .rdata           (rdata),
    .exc_valid       (exc_valid),
    .exc_code        (exc_code),
    .exc_pc          (exc_pc),
    .exc_bd          (exc_bd),
    .exc_badvaddr_we (exc_badvaddr_we),
    .exc_badvaddr    (exc_badvaddr),
    .ll_set          (ll_set),
    .eret            (eret),
    .hw_int          (hw_int),
    .status_out      (status_out),
    .cause_out       (cause_out),
    .epc_out         (epc_out),
    .errorepc_out    (errorepc_out),
    .llbit           (llbit),
    .int_pending     (int_pending)
  );

  // Behavioural model. Count is held as a load value plus elapsed cycles.
  logic [31:0] m_status, m_epc, m_errorepc, m_badv, m_compare, m_count_base, m_lladdr;
  logic        m_bd, m_ti, m_llbit;
  logic [4:0]  m_exc;
  logic [1:0]  m_ip_sw;
  logic [5:0]  m_ip_hw;
  int          m_cyc;

  function automatic logic [31:0] m_count();
    return m_count_base + 32'(m_cyc / COUNT_DIV);
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'b0, m_ip_hw, m_ip_sw, 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic m_int();
    return m_status[0] & ~m_status[1] & ~m_status[2] &
           (|({m_ip_hw, m_ip_sw} & m_status[15:8]));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    if (s != 3'd0) return 32'h0;
    case (a)
      5'd8:  return m_badv;
      5'd9:  return m_count();
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause();
      5'd14: return m_epc;
      5'd15: return PRID;
      5'd16: return CONFIG;
      5'd17: return m_lladdr;
      5'd30: return m_errorepc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0004; m_epc = '0; m_errorepc = '0; m_badv = '0;
    m_compare = 32'hFFFF_FFFF; m_count_base = '0; m_cyc = 0; m_lladdr = '0;
    m_bd = 1'b0; m_ti = 1'b0; m_llbit = 1'b0; m_exc = '0; m_ip_sw = '0; m_ip_hw = '0;
  endtask

  task automatic model_update();
    logic [31:0] cnt;
    logic        nti, wv;
    if (reset) begin
      model_reset();
      return;
    end
    cnt = m_count();
    wv  = we && !exc_valid && wsel == 3'd0;
    nti = m_ti;
    if (cnt == m_compare) nti = 1'b1;
    if (wv && waddr == 5'd11) nti = 1'b0;
    if (wv && waddr == 5'd9) begin
      m_count_base = wdata;
      m_cyc = 0;
    end else begin
      m_cyc++;
    end
    m_ti    = nti;
    m_ip_hw = {nti | hw_int[5], hw_int[4:0]};
    if (exc_valid) begin
      if (!m_status[1]) begin
        m_epc = exc_pc;
        m_bd  = exc_bd;
      end
      m_exc = exc_code;
      m_status[1] = 1'b1;
      if (exc_badvaddr_we) m_badv = exc_badvaddr;
    end else if (wv) begin
      case (waddr)
        5'd8:  m_badv     = wdata;
        5'd11: m_compare  = wdata;
        5'd12: m_status   = wdata & 32'h0040_FF07;
        5'd13: m_ip_sw    = wdata[9:8];
        5'd14: m_epc      = wdata;
        5'd17: m_lladdr   = wdata >> 4;
        5'd30: m_errorepc = wdata;
        default: ;
      endcase
    end
    if (eret) m_llbit = 1'b0;
    else if (ll_set) m_llbit = 1'b1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check_val("status_out", status_out, m_status);
    check_val("cause_out", cause_out, m_cause());
    check_val("epc_out", epc_out, m_epc);
    check_val("errorepc_out", errorepc_out, m_errorepc);
    check_val("llbit", {31'b0, llbit}, {31'b0, m_llbit});
    check_val("int_pending", {31'b0, int_pending}, {31'b0, m_int()});
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wsel = 3'd0; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    raddr = a; rsel = 3'd0;
    #1;
    check_val(tag, rdata, exp);
    check_val({tag, "_model"}, rdata, m_read(a, 3'd0));
  endtask

  initial begin
    int regs[10] = '{8, 9, 11, 12, 13, 14, 15, 16, 17, 30};
    logic [4:0] ra;
    logic [2:0] rs;

    model_reset();
    reset = 1'b1; we = 1'b0; waddr = '0; wsel = '0; wdata = '0; raddr = '0; rsel = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
    exc_badvaddr_we = 1'b0; exc_badvaddr = '0; ll_set = 1'b0; eret = 1'b0; hw_int = '0;
    step();
    step();
    reset = 1'b0;

    // Reset values and unimplemented register.
    rd_chk("rst_status", 5'd12, 32'h0040_0004);
    rd_chk("rst_prid", 5'd15, PRID);
    rd_chk("rst_unimpl", 5'd5, 32'h0);
    rd_chk("rst_compare", 5'd11, 32'hFFFF_FFFF);

    // Writable masks.
    wr(5'd12, 32'hFFFF_FFFF);
    rd_chk("status_mask", 5'd12, 32'h0040_FF07);
    wr(5'd13, 32'hFFFF_FFFF);
    rd_chk("cause_mask", 5'd13, 32'h0000_0300);
    wr(5'd12, 32'h0);
    wr(5'd13, 32'h0);

    // Timer: Count=5, Compare=8, one increment every two cycles.
    wr(5'd9, 32'd5);
    wr(5'd11, 32'd8);
    repeat (5) step();
    rd_chk("count_8", 5'd9, 32'd8);
    check_val("ti_before", {31'b0, cause_out[30]}, 32'd0);
    step();
    check_val("ti_ip7", {30'b0, cause_out[30], cause_out[15]}, 32'd3);
    wr(5'd12, 32'h0000_8001);
    check_val("timer_int", {31'b0, int_pending}, 32'd1);
    wr(5'd11, 32'hFFFF_0000);
    check_val("ti_clear", {31'b0, cause_out[30]}, 32'd0);

    // Exception beats a concurrent write.
    exc_valid = 1'b1; exc_pc = 32'hBFC0_0100; exc_bd = 1'b1; exc_code = 5'd4;
    exc_badvaddr_we = 1'b1; exc_badvaddr = 32'h1233;
    we = 1'b1; waddr = 5'd14; wsel = 3'd0; wdata = 32'hDEAD_BEEF;
    step();
    we = 1'b0; exc_valid = 1'b0; exc_badvaddr_we = 1'b0;
    check_val("exc_epc", epc_out, 32'hBFC0_0100);
    check_val("exc_bd", {31'b0, cause_out[31]}, 32'd1);
    check_val("exc_code", {27'b0, cause_out[6:2]}, 32'd4);
    check_val("exc_exl", {31'b0, status_out[1]}, 32'd1);
    rd_chk("exc_badv", 5'd8, 32'h1233);
    exc_valid = 1'b1; exc_pc = 32'h1234_5678; exc_bd = 1'b0; exc_code = 5'd5;
    step();
    exc_valid = 1'b0;
    check_val("nested_epc", epc_out, 32'hBFC0_0100);
    check_val("nested_bd", {31'b0, cause_out[31]}, 32'd1);
    check_val("nested_code", {27'b0, cause_out[6:2]}, 32'd5);

    // Count wrap and hardware interrupt.
    wr(5'd9, 32'hFFFF_FFFF);
    step();
    step();
    rd_chk("count_wrap", 5'd9, 32'h0);
    wr(5'd12, 32'h0000_0401);
    check_val("hw_int_idle", {31'b0, int_pending}, 32'd0);
    hw_int = 6'b000001;
    step();
    check_val("hw_int_taken", {31'b0, int_pending}, 32'd1);
    wr(5'd12, 32'h0000_0403);
    check_val("hw_int_exl", {31'b0, int_pending}, 32'd0);
    hw_int = '0;

    // Link bit and LLAddr.
    ll_set = 1'b1;
    step();
    check_val("ll_set", {31'b0, llbit}, 32'd1);
    eret = 1'b1;
    step();
    ll_set = 1'b0; eret = 1'b0;
    check_val("ll_eret", {31'b0, llbit}, 32'd0);
    wr(5'd17, 32'h1234_5678);
    rd_chk("lladdr", 5'd17, 32'h0123_4567);

    // Randomized traffic, including occasional mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      we    = ($urandom_range(0, 2) == 0);
      waddr = ($urandom_range(0, 9) < 7) ? 5'(regs[$urandom_range(0, 9)]) : 5'($urandom);
      wsel  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
      wdata = $urandom;
      if (waddr == 5'd11 && $urandom_range(0, 1) == 1)
        wdata = m_count() + 32'($urandom_range(0, 6));
      if (waddr == 5'd12 && $urandom_range(0, 1) == 1)
        wdata = wdata & 32'hFFFF_FFF9;  // favour IE with EXL/ERL clear
      exc_valid       = ($urandom_range(0, 15) == 0);
      exc_code        = 5'($urandom);
      exc_pc          = $urandom;
      exc_bd          = 1'($urandom);
      exc_badvaddr_we = 1'($urandom);
      exc_badvaddr    = $urandom;
      if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom);
      ll_set = ($urandom_range(0, 7) == 0);
      eret   = ($urandom_range(0, 7) == 0);
      step();
      ra = ($urandom_range(0, 3) != 0) ? 5'(regs[$urandom_range(0, 9)]) : 5'($urandom);
      rs = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
      raddr = ra; rsel = rs;
      #1;
      check_val("rand_rdata", rdata, m_read(ra, rs));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cop0_regfile.md
Name: cop0_regfile

Overview:
- Coprocessor-0 register file: the receiving end of the execute-stage COP0 write-value path.
- Accepts the committed COP0 write (MTC0 data, ERET/EI/DI/EXL-modified Status, LL address) at writeback.
- Records exception state (EPC, Cause, BadVAddr), runs the Count/Compare timer and hardware-interrupt sampling.
- Provides a read port plus live Status/Cause/EPC/ErrorEPC outputs to decode, execute and the exception unit.

Parameters:
PRID, 32'h00018000, read-only Processor ID value (reg 15 sel 0)
CONFIG, 32'h80000000, read-only Config value (reg 16 sel 0)
COUNT_DIV, 2, core cycles per Count increment (must be ≥1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
we  in  1  commit COP0 write this cycle
waddr  in  5  destination register number
wsel  in  3  destination select
wdata  in  32  value to write (already merged Status, rt, or LL address)
raddr  in  5  read register number
rsel  in  3  read select
rdata  out  32  read data, combinational
exc_valid  in  1  exception commit this cycle
exc_code  in  5  ExcCode
exc_pc  in  32  faulting PC (already branch-adjusted by source)
exc_bd  in  1  faulting instruction in delay slot
exc_badvaddr_we  in  1  update BadVAddr with exception
exc_badvaddr  in  32  faulting address
ll_set  in  1  LL committed; sets LLbit
eret  in  1  ERET committed; clears LLbit
hw_int  in  6  external interrupt lines, level-sensitive
status_out  out  32  current Status
cause_out  out  32  current Cause
epc_out  out  32  current EPC
errorepc_out  out  32  current ErrorEPC
llbit  out  1  LL/SC link bit
int_pending  out  1  interrupt to be taken

Behaviour:
- Registers (reg,sel): BadVAddr(8,0), Count(9,0), Compare(11,0), Status(12,0), Cause(13,0), EPC(14,0), PRId(15,0), Config(16,0), LLAddr(17,0), ErrorEPC(30,0). Any other (reg,sel): reads 0, writes ignored.
- Reset: Status=32'h0040_0004 (BEV=1, ERL=1); Cause, EPC, ErrorEPC, BadVAddr, Count, LLAddr=0; Compare=32'hFFFF_FFFF; llbit=0; divider=0.
- Status writable mask 32'h0040_FF07 (BEV, IM[7:0], ERL, EXL, IE); other bits read 0.
- Cause writable bits: IP[1:0] (bits 9:8) only. IP[7:2] = {TI | hw_int[5], hw_int[4:0]}, sampled into a register each cycle (1-cycle latency). BD=bit31, TI=bit30, ExcCode=bits 6:2.
- Write: on we, target register updates on next edge. LLAddr stores wdata[31:4] in bits 27:0. Read-only registers ignore writes.
- Read: rdata reflects register state, with no write bypass. Same-cycle write is visible next cycle; the pipeline forwards.
- Count: divider counts 0..COUNT_DIV-1; Count increments by 1 when divider wraps, 32-bit wrap 0xFFFFFFFF→0. MTC0 Count loads wdata and resets the divider; the write wins over the increment.
- Timer: TI set on the cycle after Count==Compare (registered compare). Write to Compare clears TI, and the clear wins over a same-cycle match.
- Exception (exc_valid) has priority over we in the same cycle; the write is dropped.
  - If Status.EXL=0: EPC=exc_pc, Cause.BD=exc_bd.
  - If EXL already 1: EPC and BD unchanged.
  - Always: ExcCode=exc_code, EXL=1. BadVAddr=exc_badvaddr when exc_badvaddr_we.
- ERET Status change arrives via we/wdata. The eret input only clears llbit.
- llbit: ll_set sets it, eret clears it, eret wins if both. ll_set does not write LLAddr; the LL address arrives via we to (17,0).
- int_pending = Status.IE & ~EXL & ~ERL & |(Cause.IP & Status.IM), combinational from registered state.
- Reset asserted mid-operation: all state returns to reset values on that edge regardless of we/exc_valid.

Test Plan:
1. Reset, then read (12,0) → 32'h00400004; (15,0) → PRID; (5,0) → 0.
2. Write Status=32'hFFFFFFFF → readback 32'h0040FF07. Write Cause=32'hFFFFFFFF → only bits 9:8 set.
3. COUNT_DIV=2: write Count=5, Compare=8 → Count reads 8 six cycles later. TI=1 and Cause bit 15=1 one cycle after match. Status=32'h00008001 → int_pending=1. Write Compare → TI=0.
4. Exception with EXL=0: exc_pc=32'hBFC00100, exc_bd=1, code 4, badvaddr 32'h1233, concurrent we → EPC=BFC00100, BD=1, ExcCode=4, BadVAddr=1233, EXL=1, write dropped. Second exception with EXL=1: EPC unchanged.
5. Count=32'hFFFFFFFF wraps to 0. hw_int[0]=1 with IM2=1, IE=1 → int_pending one cycle later. EXL=1 → int_pending masked.
6. ll_set → llbit=1. ll_set and eret together → llbit=0. LLAddr write 32'h12345678 → reads 32'h01234567.
